// File: rtl/fog_sim_pkg.sv
// Shared definitions for the FOG closed-loop simulation blocks.
// Holds ADC scaling, the model state encoding, LFSR constants and the output clamp.
package fog_sim_pkg;

    localparam int ADC_W   = 14;
    localparam int ADC_MAX = 16383;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STABLE = 2'd2
    } fog_state_e;

    // Clamp a wide signed sum into the unsigned ADC code range.
    function automatic logic [ADC_W-1:0] sat_adc(input logic signed [33:0] x);
        if (x < 34'sd0)
            return '0;
        else if (x > 34'(ADC_MAX))
            return ADC_W'(ADC_MAX);
        else
            return x[ADC_W-1:0];
    endfunction

endpackage

// File: rtl/fog_lfsr16.sv
// 16-bit Galois LFSR used as the detector noise source.
// Free-running: it advances every clock whenever reset is released.
module fog_lfsr16
    import fog_sim_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= LFSR_SEED;
        else
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : 16'h0000);
    end

endmodule

// File: rtl/fog_adc_model.sv
// Behavioural photodetector/ADC model: loop delay, post-edge transient,
// signed rate/feedback error, optional LFSR noise and output saturation.
module fog_adc_model
    import fog_sim_pkg::*;
#(
    parameter int LOOP_DLY  = 8,
    parameter int TRANS_CYC = 12,
    parameter int NOISE_SHR = 12,
    parameter int BIAS      = 8192
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_status,
    input  logic signed [31:0] i_rate,
    input  logic signed [31:0] i_fb,
    input  logic [13:0]        i_spike_amp,
    input  logic               i_noise_en,
    output logic [13:0]        o_adc_data,
    output logic               o_settle,
    output logic [1:0]         o_cstate
);

    localparam logic signed [33:0] BIAS_S   = 34'(BIAS);
    localparam logic [7:0]         CNT_LOAD = (TRANS_CYC > 0) ? 8'(TRANS_CYC - 1) : 8'd0;

    logic        ds;
    logic        ds_q;
    logic        ds_rise;
    logic        ds_fall;
    logic        ds_edge;

    fog_state_e  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        dir_neg, dir_neg_nxt;

    logic [15:0]        lfsr_q;
    logic signed [15:0] noise_sh;
    logic signed [33:0] noise_ext;
    logic signed [33:0] noise_term;
    logic signed [33:0] spike_ext;
    logic signed [33:0] spike_term;
    logic signed [33:0] s_err;
    logic signed [33:0] v_stable;
    logic signed [33:0] sum;

    // Optical loop delay on the modulation half flag; keeps shifting even when disabled.
    generate
        if (LOOP_DLY == 0) begin : g_no_dly
            assign ds = i_status;
        end else begin : g_dly
            logic [LOOP_DLY-1:0] chain;
            logic [LOOP_DLY:0]   chain_in;

            assign chain_in = {chain, i_status};
            assign ds       = chain[LOOP_DLY-1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    chain <= '0;
                else
                    chain <= chain_in[LOOP_DLY-1:0];
            end
        end
    endgenerate

    assign ds_rise = ds & ~ds_q;
    assign ds_fall = ~ds & ds_q;
    assign ds_edge = ds_rise | ds_fall;

    fog_lfsr16 u_lfsr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .q     (lfsr_q)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dir_neg_nxt = dir_neg;
        if (!i_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (ds_edge) begin
            dir_neg_nxt = ds_fall;
            if (TRANS_CYC > 0) begin
                state_nxt = SETTLE;
                cnt_nxt   = CNT_LOAD;
            end else begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        end else if (state == SETTLE) begin
            if (cnt == 8'd0)
                state_nxt = STABLE;
            else
                cnt_nxt = cnt - 8'd1;
        end
    end

    assign s_err     = {{2{i_rate[31]}}, i_rate} - {{2{i_fb[31]}}, i_fb};
    assign v_stable  = ds ? (BIAS_S + s_err) : (BIAS_S - s_err);
    assign noise_sh  = $signed(lfsr_q) >>> NOISE_SHR;
    assign noise_ext = {{18{noise_sh[15]}}, noise_sh};
    assign spike_ext = {20'b0, i_spike_amp};

    // Output is formed from the next state so data and o_settle change on the same edge.
    always_comb begin
        noise_term = i_noise_en ? noise_ext : 34'sd0;
        spike_term = dir_neg_nxt ? -spike_ext : spike_ext;
        case (state_nxt)
            SETTLE:  sum = v_stable + spike_term + noise_term;
            STABLE:  sum = v_stable + noise_term;
            default: sum = BIAS_S;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ds_q       <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            dir_neg    <= 1'b0;
            o_adc_data <= 14'(BIAS);
        end else begin
            ds_q       <= ds;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dir_neg    <= dir_neg_nxt;
            o_adc_data <= sat_adc(sum);
        end
    end

    assign o_settle = (state == SETTLE);
    assign o_cstate = state;

endmodule

// File: tb/tb_fog_adc_model.sv
// Directed bench for fog_adc_model: a delayed/transient instance and a
// zero-delay, zero-transient instance share one stimulus stream.
module tb_fog_adc_model;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               status;
    logic signed [31:0] rate;
    logic signed [31:0] fb;
    logic [13:0]        spike;
    logic               noise_en;

    logic [13:0] adc0, adc1;
    logic        settle0, settle1;
    logic [1:0]  cstate0, cstate1;

    int total = 0;
    int bad   = 0;

    logic [15:0] lfsr_m, lfsr_prev;

    always #5 clk = ~clk;

    fog_adc_model #(.LOOP_DLY(8), .TRANS_CYC(12), .NOISE_SHR(12), .BIAS(8192)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_status    (status),
        .i_rate      (rate),
        .i_fb        (fb),
        .i_spike_amp (spike),
        .i_noise_en  (noise_en),
        .o_adc_data  (adc0),
        .o_settle    (settle0),
        .o_cstate    (cstate0)
    );

    fog_adc_model #(.LOOP_DLY(0), .TRANS_CYC(0), .NOISE_SHR(12), .BIAS(8192)) dut_fast (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_status    (status),
        .i_rate      (rate),
        .i_fb        (fb),
        .i_spike_amp (spike),
        .i_noise_en  (noise_en),
        .o_adc_data  (adc1),
        .o_settle    (settle1),
        .o_cstate    (cstate1)
    );

    // Reference noise source; lfsr_prev is the value the DUT used for its latest sample.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int model_noise();
        logic signed [15:0] n16;
        n16 = lfsr_prev;
        return int'(n16) >>> 12;
    endfunction

    initial begin : stim
        int n_settle;

        rst_n    = 1'b0;
        en       = 1'b0;
        status   = 1'b0;
        rate     = 32'sd0;
        fb       = 32'sd0;
        spike    = 14'd0;
        noise_en = 1'b0;

        // Reset state
        tick(2);
        check("rst_adc", 32'(adc0), 32'd8192);
        check("rst_settle", 32'(settle0), 32'd0);
        check("rst_cstate", 32'(cstate0), 32'd0);
        check("rst_adc_fast", 32'(adc1), 32'd8192);

        rst_n = 1'b1;
        en    = 1'b1;
        rate  = 32'sd100;
        spike = 14'd500;
        tick(20);
        check("idle_no_edge_adc", 32'(adc0), 32'd8192);
        check("idle_no_edge_state", 32'(cstate0), 32'd0);

        // Rising edge: spike 9 clocks after the status edge, 12 cycles long
        status   = 1'b1;
        n_settle = 0;
        tick(8);
        check("rise_pre_adc", 32'(adc0), 32'd8192);
        check("rise_pre_settle", 32'(settle0), 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (settle0) n_settle++;
            if (k == 0) begin
                check("rise_spike_first", 32'(adc0), 32'd8792);
                check("rise_settle_first", 32'(settle0), 32'd1);
                check("rise_cstate_first", 32'(cstate0), 32'd1);
            end
            if (k == 11) check("rise_spike_last", 32'(adc0), 32'd8792);
            if (k == 12) begin
                check("high_stable_adc", 32'(adc0), 32'd8292);
                check("high_stable_cstate", 32'(cstate0), 32'd2);
            end
        end
        check("rise_settle_len", 32'(n_settle), 32'd12);

        // Rate change is visible one clock later, not loop-delayed
        rate = 32'sd200;
        tick(1);
        check("rate_latency", 32'(adc0), 32'd8392);
        rate = 32'sd100;
        tick(1);
        check("rate_restore", 32'(adc0), 32'd8292);

        // Noise added in STABLE
        noise_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("noise_stable", 32'(adc0), 32'(8292 + model_noise()));
        end
        noise_en = 1'b0;
        tick(1);
        check("noise_off", 32'(adc0), 32'd8292);
        tick(16);

        // Falling edge
        status = 1'b0;
        tick(9);
        check("fall_spike_first", 32'(adc0), 32'd7592);
        check("fall_settle", 32'(settle0), 32'd1);
        tick(11);
        check("fall_spike_last", 32'(adc0), 32'd7592);
        tick(1);
        check("low_stable_adc", 32'(adc0), 32'd8092);
        check("low_stable_settle", 32'(settle0), 32'd0);

        // Feedback cancels rate: only spikes remain
        fb = 32'sd100;
        tick(1);
        check("fb_cancel_low", 32'(adc0), 32'd8192);
        status = 1'b1;
        tick(9);
        check("fb_cancel_spike", 32'(adc0), 32'd8692);
        tick(12);
        check("fb_cancel_high", 32'(adc0), 32'd8192);

        // Saturation
        fb   = 32'sd0;
        rate = 32'sd20000;
        tick(1);
        check("sat_high", 32'(adc0), 32'd16383);
        status = 1'b0;
        tick(9);
        check("sat_low_spike", 32'(adc0), 32'd0);
        tick(12);
        check("sat_low_stable", 32'(adc0), 32'd0);
        check("sat_low_cstate", 32'(cstate0), 32'd2);
        rate = 32'sd100;
        tick(1);
        check("unsat_low", 32'(adc0), 32'd8092);

        // Retrigger: second edge 5 cycles after the first delayed edge
        status   = 1'b1;
        n_settle = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 5) status = 1'b0;
            if (settle0) n_settle++;
            if (k == 13) check("retrig_first_spike", 32'(adc0), 32'd8792);
            if (k == 14) begin
                check("retrig_second_spike", 32'(adc0), 32'd7592);
                check("retrig_second_settle", 32'(settle0), 32'd1);
            end
            if (k == 25) check("retrig_last_settle", 32'(settle0), 32'd1);
            if (k == 26) begin
                check("retrig_end_adc", 32'(adc0), 32'd8092);
                check("retrig_end_settle", 32'(settle0), 32'd0);
            end
        end
        check("retrig_settle_len", 32'(n_settle), 32'd17);

        // Zero delay, zero transient instance
        check("fast_pre", 32'(adc1), 32'd8092);
        status = 1'b1;
        tick(1);
        check("fast_rise_adc", 32'(adc1), 32'd8292);
        check("fast_rise_settle", 32'(settle1), 32'd0);
        check("fast_rise_cstate", 32'(cstate1), 32'd2);
        status = 1'b0;
        tick(1);
        check("fast_fall_adc", 32'(adc1), 32'd8092);
        check("fast_fall_settle", 32'(settle1), 32'd0);

        // Enable low forces IDLE; re-enable waits for an edge
        tick(25);
        en = 1'b0;
        tick(1);
        check("dis_adc", 32'(adc0), 32'd8192);
        check("dis_cstate", 32'(cstate0), 32'd0);
        en = 1'b1;
        tick(5);
        check("reen_idle_adc", 32'(adc0), 32'd8192);
        check("reen_idle_cstate", 32'(cstate0), 32'd0);

        // Reset asserted mid-SETTLE
        status = 1'b1;
        tick(10);
        check("pre_rst_settle", 32'(settle0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_adc", 32'(adc0), 32'd8192);
        check("midrst_settle", 32'(settle0), 32'd0);
        tick(1);
        check("midrst_cstate", 32'(cstate0), 32'd0);
        rst_n = 1'b1;
        tick(8);
        check("post_rst_idle_adc", 32'(adc0), 32'd8192);
        check("post_rst_idle_cstate", 32'(cstate0), 32'd0);
        tick(1);
        check("post_rst_edge_adc", 32'(adc0), 32'd8792);
        check("post_rst_edge_cstate", 32'(cstate0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fog_adc_model.md
# fog_adc_model

Behavioural photodetector/ADC model for closed-loop FOG simulation. It consumes the modulation half-cycle flag produced by the modulation generator and drives the 14-bit ADC sample stream that the error-signal generator demodulates. The model applies the optical loop delay, a post-edge transient, a signed rate/feedback error term, optional LFSR noise and output saturation. It is synthesizable and sits in the sim top between modulation and error-signal generation, replacing the real ADC.

## Interface
- LOOP_DLY, 8: loop delay in clocks, range 0..63.
- TRANS_CYC, 12: post-edge transient length in clocks, range 0..255.
- NOISE_SHR, 12: arithmetic right shift applied to LFSR noise, range 0..15.
- BIAS, 8192: ADC code for zero optical error (offset-binary mid-scale).
- i_clk  in  1: system clock.
- i_rst_n  in  1: asynchronous active-low reset.
- i_en  in  1: model enable; low forces IDLE and a BIAS output.
- i_status  in  1: modulation half flag (1 = high half).
- i_rate  in  32: signed simulated Sagnac error, in ADC LSB.
- i_fb  in  32: signed feedback (ramp step) phase, in ADC LSB.
- i_spike_amp  in  14: unsigned transient spike magnitude.
- i_noise_en  in  1: add LFSR noise.
- o_adc_data  out  14: unsigned ADC sample.
- o_settle  out  1: high while the transient is being applied.
- o_cstate  out  2: current state, for debug.

## Operation
- Delay line: i_status is shifted through a LOOP_DLY-deep register chain. The delayed flag is ds. With LOOP_DLY=0, ds = i_status.
- Edge detect on ds: dir = +1 for a rising edge, -1 for a falling edge.
- Error term: s = i_rate − i_fb, computed as 34-bit signed. Stable value: v = BIAS + s when ds=1, v = BIAS − s when ds=0.
- States:
  - IDLE(0): output BIAS. Leave on the first ds edge with i_en=1. Go to SETTLE if TRANS_CYC>0, otherwise STABLE.
  - SETTLE(1): v + dir·i_spike_amp. Counter loads TRANS_CYC−1 on the edge and decrements each clock. Go to STABLE after the cycle in which the count = 0.
  - STABLE(2): v.
- Any ds edge while in SETTLE or STABLE reloads the counter and dir, then enters SETTLE. If TRANS_CYC=0 it stays in or enters STABLE.
- i_en low: synchronous return to IDLE and counter cleared. The delay line keeps shifting.
- Noise: a 16-bit Galois LFSR (poly 0xB400, seed 0xACE1) advances every clock regardless of i_en. Noise = $signed(lfsr) >>> NOISE_SHR. It is added in SETTLE and STABLE when i_noise_en=1.
- Saturation: the final 34-bit sum is clamped to 0..16383 before registering.
- o_settle = (state == SETTLE). o_cstate = state encoding.

## Timing
- Reset values:
  - o_adc_data = BIAS.
  - o_settle = 0.
  - o_cstate = 0.
  - Delay chain all 0, counter 0, LFSR = 0xACE1.
- Edge-to-output latency: an i_status edge at cycle t changes o_adc_data at t+LOOP_DLY+1, with o_settle asserted in that same cycle.
- o_settle stays high for exactly TRANS_CYC output cycles, assuming no new edge arrives.
- i_rate/i_fb changes appear on o_adc_data 1 cycle later; they are not delayed by LOOP_DLY.
- All outputs are registered. There is no combinational path from input to output.
- Reset asserted mid-operation: all state clears immediately. After release the model starts in IDLE and waits for a new ds edge.

## Structure
- Shared package fog_sim_pkg holds:
  - ADC_W=14, ADC_MAX=16383.
  - The state enum {IDLE, SETTLE, STABLE}.
  - LFSR_POLY=16'hB400, LFSR_SEED=16'hACE1.
- Sub-module fog_lfsr16 (clk, rst_n, output q[15:0]) implements the Galois LFSR. Delay line, FSM and arithmetic stay in fog_adc_model.

## Test plan
- LOOP_DLY=8, TRANS_CYC=12, rate=100, fb=0, spike=500, noise off, toggle status every 50 clk. Required: high half settles to 8292, low half to 8092. After a rising edge, 8792 for 12 cycles, starting 9 clocks after the edge. After a falling edge, 7592.
- rate=100, fb=100. Required: steady output 8192 in both halves; only the spikes remain.
- rate=+20000, status=1. Required: o_adc_data=16383. With status=0: 0.
- TRANS_CYC=12, second status edge 5 cycles after the first delayed edge. Required: counter restarts, o_settle high 17 consecutive cycles, spike sign follows the second edge.
- TRANS_CYC=0, LOOP_DLY=0. Required: no o_settle pulse; output switches 1 clk after the status edge.
- Reset asserted mid-SETTLE. Required: next cycle o_adc_data=8192, o_settle=0, o_cstate=0. Stays IDLE until the next delayed edge.
